mem_port_arbiter: RTL and testbench

Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage). It sits between the pipeline's two SRAM-like masters and the memory/bridge slave. Arbitration is fixed-priority with data first and a starvation guard for fetch. An in-order tag FIFO routes each response back to the master that issued it, with zero added latency.

---
 rtl/mem_port_arbiter_if.sv | 27 ++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// SRAM-like request/response bus shared by the pipeline masters and the
// memory/bridge slave.
//   req/wr/size/wstrb/addr/wdata : driven by the master
//   addr_ok/data_ok/rdata        : driven by the slave
// modport master : the side that issues requests
// modport slave  : the side that accepts requests and returns responses
interface mem_port_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the instruction-fetch master
// and the data-access master. Fixed priority to data, with a starvation
// guard that forces one fetch through after STARVE_LIMIT consecutive data
// grants while fetch waits. An in-order tag FIFO steers each response back
// to the master that issued the request; all handshake paths are
// combinational so the arbiter adds no latency.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inst       : fetch master bus (arbiter acts as its slave)
//   data       : data master bus (arbiter acts as its slave)
//   mem        : downstream memory bus (arbiter acts as its master)
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    inst,
  mem_port_arbiter_if.slave    data,
  mem_port_arbiter_if.master   mem
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic          locked_reg;
  logic          lock_src_reg;   // 0 = inst, 1 = data
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [SW-1:0] streak_reg;
  logic          tag_mem [MAX_OUTSTANDING];

  logic grant_data;
  logic any_req;
  logic room;
  logic mem_req;
  logic push;
  logic pop;
  logic head;
  logic starved;

  assign any_req = inst.req | data.req;
  assign room    = count_reg < CW'(MAX_OUTSTANDING);
  // Reset gating keeps every output quiet while reset is held.
  assign mem_req = ~reset & any_req & room;
  assign starved = (streak_reg == SW'(STARVE_LIMIT)) & inst.req;

  // A stalled handshake pins the grant so the slave sees a stable request.
  always_comb begin
    grant_data = 1'b0;
    if (locked_reg)
      grant_data = lock_src_reg;
    else if (data.req && !starved)
      grant_data = 1'b1;
  end

  assign mem.req   = mem_req;
  assign mem.wr    = mem_req & (grant_data ? data.wr : inst.wr);
  assign mem.size  = mem_req ? (grant_data ? data.size  : inst.size)  : 2'b0;
  assign mem.wstrb = mem_req ? (grant_data ? data.wstrb : inst.wstrb) : 4'b0;
  assign mem.addr  = mem_req ? (grant_data ? data.addr  : inst.addr)  : 32'b0;
  assign mem.wdata = mem_req ? (grant_data ? data.wdata : inst.wdata) : 32'b0;

  assign push = mem_req & mem.addr_ok;
  // A response with nothing outstanding is a slave protocol error; drop it.
  assign pop  = ~reset & mem.data_ok & (count_reg != '0);
  assign head = tag_mem[rd_ptr_reg];

  assign inst.addr_ok = push & ~grant_data;
  assign data.addr_ok = push &  grant_data;
  assign inst.data_ok = pop  & ~head;
  assign data.data_ok = pop  &  head;
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  // Tag storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr_reg] <= grant_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked_reg   <= 1'b0;
      lock_src_reg <= 1'b0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      streak_reg   <= '0;
    end else begin
      if (mem_req && !mem.addr_ok) begin
        locked_reg   <= 1'b1;
        lock_src_reg <= grant_data;
      end else if (mem.addr_ok) begin
        locked_reg   <= 1'b0;
      end

      count_reg <= count_reg + CW'(push) - CW'(pop);
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;

      if (!inst.req || inst.addr_ok)
        streak_reg <= '0;
      else if (data.addr_ok && streak_reg != SW'(STARVE_LIMIT))
        streak_reg <= streak_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  localparam logic [31:0] IADDR = 32'h1fc0_0000;
  localparam logic [31:0] DADDR = 32'h1c00_0100;

  mem_port_arbiter_if inst_bus ();
  mem_port_arbiter_if data_bus ();
  mem_port_arbiter_if mem_bus ();

  mem_port_arbiter #(
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inst(inst_bus),
    .data(data_bus),
    .mem(mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 2; inst_bus.wstrb = 4'hf;
    inst_bus.addr = IADDR; inst_bus.wdata = 32'h0;
    data_bus.req = 0; data_bus.wr = 0; data_bus.size = 2; data_bus.wstrb = 4'hf;
    data_bus.addr = DADDR; data_bus.wdata = 32'h0;
    mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    inst_bus.req = 1; data_bus.req = 1; mem_bus.addr_ok = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({mem_bus.req, mem_bus.wr, inst_bus.addr_ok, data_bus.addr_ok,
           inst_bus.data_ok, data_bus.data_ok} !== 6'b0 || mem_bus.addr !== 32'h0) begin
        errors++;
        $display("FAIL reset_quiet cycle %0d: mem_req=%b addr=%h iaok=%b daok=%b, required all 0",
                 i, mem_bus.req, mem_bus.addr, inst_bus.addr_ok, data_bus.addr_ok);
      end
      tick();
    end
    reset = 0;
    #1;
    checks++;
    if (mem_bus.req !== 1'b1 || data_bus.addr_ok !== 1'b1 || inst_bus.addr_ok !== 1'b0
        || mem_bus.addr !== DADDR) begin
      errors++;
      $display("FAIL reset_release: mem_req=%b daok=%b iaok=%b addr=%h, required 1 1 0 %h",
               mem_bus.req, data_bus.addr_ok, inst_bus.addr_ok, mem_bus.addr, DADDR);
    end
    $display("test_reset done");
    tick();
    apply_reset();
  endtask

  task automatic test_priority();
    apply_reset();
    inst_bus.req = 1; data_bus.req = 1; mem_bus.addr_ok = 1;
    data_bus.wr = 1; data_bus.size = 1; data_bus.wstrb = 4'h3; data_bus.wdata = 32'hcafe_f00d;
    #1;
    checks++;
    if (mem_bus.addr !== DADDR || data_bus.addr_ok !== 1'b1 || inst_bus.addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL priority_data: addr=%h daok=%b iaok=%b, required %h 1 0",
               mem_bus.addr, data_bus.addr_ok, inst_bus.addr_ok, DADDR);
    end
    checks++;
    if (mem_bus.wr !== 1'b1 || mem_bus.size !== 2'd1 || mem_bus.wstrb !== 4'h3
        || mem_bus.wdata !== 32'hcafe_f00d) begin
      errors++;
      $display("FAIL priority_mux: wr=%b size=%0d wstrb=%h wdata=%h, required 1 1 3 cafef00d",
               mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.wdata);
    end
    tick();
    data_bus.req = 0;
    #1;
    checks++;
    if (mem_bus.addr !== IADDR || inst_bus.addr_ok !== 1'b1 || mem_bus.wr !== 1'b0) begin
      errors++;
      $display("FAIL priority_inst_next: addr=%h iaok=%b wr=%b, required %h 1 0",
               mem_bus.addr, inst_bus.addr_ok, mem_bus.wr, IADDR);
    end
    $display("test_priority done");
    tick();
  endtask

  task automatic test_lock();
    apply_reset();
    inst_bus.req = 1; mem_bus.addr_ok = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) data_bus.req = 1;
      #1;
      checks++;
      if (mem_bus.req !== 1'b1 || mem_bus.addr !== IADDR || inst_bus.addr_ok !== 1'b0
          || data_bus.addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold cycle %0d: req=%b addr=%h iaok=%b daok=%b, required 1 %h 0 0",
                 c, mem_bus.req, mem_bus.addr, inst_bus.addr_ok, data_bus.addr_ok, IADDR);
      end
      tick();
    end
    mem_bus.addr_ok = 1;
    #1;
    checks++;
    if (inst_bus.addr_ok !== 1'b1 || data_bus.addr_ok !== 1'b0 || mem_bus.addr !== IADDR) begin
      errors++;
      $display("FAIL lock_release: iaok=%b daok=%b addr=%h, required 1 0 %h",
               inst_bus.addr_ok, data_bus.addr_ok, mem_bus.addr, IADDR);
    end
    tick();
    inst_bus.req = 0;
    #1;
    checks++;
    if (data_bus.addr_ok !== 1'b1 || mem_bus.addr !== DADDR) begin
      errors++;
      $display("FAIL lock_next_data: daok=%b addr=%h, required 1 %h",
               data_bus.addr_ok, mem_bus.addr, DADDR);
    end
    $display("test_lock done");
    tick();
  endtask

  task automatic test_outstanding();
    apply_reset();
    data_bus.req = 1; mem_bus.addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (data_bus.addr_ok !== 1'b1) begin
        errors++;
        $display("FAIL outst_accept %0d: daok=%b, required 1", i, data_bus.addr_ok);
      end
      tick();
    end
    #1;
    checks++;
    if (mem_bus.req !== 1'b0 || data_bus.addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL outst_full: mem_req=%b daok=%b, required 0 0", mem_bus.req, data_bus.addr_ok);
    end
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h11;
    #1;
    checks++;
    if (data_bus.data_ok !== 1'b1 || data_bus.rdata !== 32'h11 || mem_bus.req !== 1'b0) begin
      errors++;
      $display("FAIL outst_pop: ddok=%b rdata=%h mem_req=%b, required 1 11 0",
               data_bus.data_ok, data_bus.rdata, mem_bus.req);
    end
    tick();
    mem_bus.data_ok = 0;
    #1;
    checks++;
    if (mem_bus.req !== 1'b1 || data_bus.addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL outst_reassert: mem_req=%b daok=%b, required 1 1", mem_bus.req, data_bus.addr_ok);
    end
    tick();
    #1;
    checks++;
    if (mem_bus.req !== 1'b0) begin
      errors++;
      $display("FAIL outst_refull: mem_req=%b, required 0", mem_bus.req);
    end
    mem_bus.data_ok = 1;
    tick();
    // count 3: a push and a pop together must leave it at 3
    #1;
    checks++;
    if (data_bus.addr_ok !== 1'b1 || data_bus.data_ok !== 1'b1) begin
      errors++;
      $display("FAIL outst_pushpop: daok=%b ddok=%b, required 1 1", data_bus.addr_ok, data_bus.data_ok);
    end
    tick();
    mem_bus.data_ok = 0;
    #1;
    checks++;
    if (mem_bus.req !== 1'b1 || data_bus.addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL outst_after_pushpop: mem_req=%b daok=%b, required 1 1", mem_bus.req, data_bus.addr_ok);
    end
    tick();
    #1;
    checks++;
    if (mem_bus.req !== 1'b0) begin
      errors++;
      $display("FAIL outst_full_again: mem_req=%b, required 0", mem_bus.req);
    end
    $display("test_outstanding done");
    tick();
  endtask

  task automatic test_routing();
    logic [31:0] rd [3];
    logic        is_data [3];
    rd[0] = 32'hA; rd[1] = 32'hB; rd[2] = 32'hC;
    is_data[0] = 0; is_data[1] = 1; is_data[2] = 0;
    apply_reset();
    mem_bus.addr_ok = 1;
    for (int i = 0; i < 3; i++) begin
      inst_bus.req = !is_data[i]; data_bus.req = is_data[i];
      tick();
    end
    inst_bus.req = 0; data_bus.req = 0;
    mem_bus.data_ok = 1;
    for (int i = 0; i < 3; i++) begin
      mem_bus.rdata = rd[i];
      #1;
      checks++;
      if (inst_bus.data_ok !== !is_data[i] || data_bus.data_ok !== is_data[i]
          || (is_data[i] ? data_bus.rdata : inst_bus.rdata) !== rd[i]) begin
        errors++;
        $display("FAIL route %0d: idok=%b ddok=%b irdata=%h drdata=%h, required idok=%b ddok=%b rdata=%h",
                 i, inst_bus.data_ok, data_bus.data_ok, inst_bus.rdata, data_bus.rdata,
                 !is_data[i], is_data[i], rd[i]);
      end
      tick();
    end
    mem_bus.rdata = 32'hD;
    #1;
    checks++;
    if (inst_bus.data_ok !== 1'b0 || data_bus.data_ok !== 1'b0) begin
      errors++;
      $display("FAIL route_spurious: idok=%b ddok=%b, required 0 0", inst_bus.data_ok, data_bus.data_ok);
    end
    tick();
    mem_bus.data_ok = 0;
    data_bus.req = 1;
    tick();
    data_bus.req = 0;
    mem_bus.data_ok = 1; mem_bus.rdata = 32'hE;
    #1;
    checks++;
    if (data_bus.data_ok !== 1'b1 || inst_bus.data_ok !== 1'b0 || data_bus.rdata !== 32'hE) begin
      errors++;
      $display("FAIL route_after_spurious: ddok=%b idok=%b rdata=%h, required 1 0 e",
               data_bus.data_ok, inst_bus.data_ok, data_bus.rdata);
    end
    $display("test_routing done");
    tick();
    mem_bus.data_ok = 0;
  endtask

  task automatic test_starvation();
    apply_reset();
    inst_bus.req = 1; data_bus.req = 1; mem_bus.addr_ok = 1;
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 8; i++) begin
        #1;
        checks++;
        if (data_bus.addr_ok !== 1'b1 || inst_bus.addr_ok !== 1'b0) begin
          errors++;
          $display("FAIL starve_data r%0d g%0d: daok=%b iaok=%b, required 1 0",
                   round, i, data_bus.addr_ok, inst_bus.addr_ok);
        end
        tick();
        mem_bus.data_ok = 1;  // one response per cycle keeps count at 1
      end
      #1;
      checks++;
      if (inst_bus.addr_ok !== 1'b1 || data_bus.addr_ok !== 1'b0 || mem_bus.addr !== IADDR) begin
        errors++;
        $display("FAIL starve_inst r%0d: iaok=%b daok=%b addr=%h, required 1 0 %h",
                 round, inst_bus.addr_ok, data_bus.addr_ok, mem_bus.addr, IADDR);
      end
      tick();
    end
    #1;
    checks++;
    if (data_bus.addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL starve_data_resume: daok=%b, required 1", data_bus.addr_ok);
    end
    $display("test_starvation done");
    tick();
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    reset = 1;
    test_reset();
    test_priority();
    test_lock();
    test_outstanding();
    test_routing();
    test_starvation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
